fp9_addsub_seq: RTL and testbench



---
 rtl/fp9_pkg.sv | 26 ++
 rtl/fp9_unpack.sv | 52 +++++
 rtl/fp9_addsub_seq.sv | 149 ++++++++++++++
 tb/tb_fp9_addsub_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fp9_pkg.sv
// Shared constants, operand layout and FSM state type for the 9-bit
// floating-point add/subtract unit.
package fp9_pkg;

    localparam int unsigned EXP_W   = 4;
    localparam int unsigned FRAC_W  = 4;
    localparam int unsigned SIG_W   = 6;
    localparam int unsigned BIAS    = 8;
    // Largest encodable exponent; one step past it is an overflow.
    localparam int unsigned EXP_MAX = 2 * BIAS - 1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp9_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_DONE
    } fp9_state_e;

endpackage

// File: rtl/fp9_unpack.sv
// Combinational operand preparation: zero detect, magnitude ordering,
// alignment distance, effective operation and result sign.
module fp9_unpack
    import fp9_pkg::*;
(
    input  logic [8:0]       a,
    input  logic [8:0]       b,
    input  logic             op,
    output logic [SIG_W-1:0] x_sig,
    output logic [SIG_W-1:0] y_sig,
    output logic [EXP_W-1:0] x_exp,
    output logic [2:0]       k,
    output logic             eff_sub,
    output logic             res_sign
);

    fp9_t fa;
    fp9_t fb;
    logic a_nz;
    logic b_nz;
    logic sb_eff;
    logic swap;
    logic [FRAC_W-1:0] frac_a;
    logic [FRAC_W-1:0] frac_b;
    logic [SIG_W-1:0]  sig_a;
    logic [SIG_W-1:0]  sig_b;
    logic [EXP_W-1:0]  y_exp;
    logic [EXP_W-1:0]  diff;

    assign fa     = a;
    assign fb     = b;
    assign a_nz   = (fa.exp != '0);
    assign b_nz   = (fb.exp != '0);
    // A zero exponent means zero, so its fraction must not affect ordering or sum.
    assign frac_a = a_nz ? fa.frac : '0;
    assign frac_b = b_nz ? fb.frac : '0;
    assign sig_a  = a_nz ? {1'b1, frac_a, 1'b0} : '0;
    assign sig_b  = b_nz ? {1'b1, frac_b, 1'b0} : '0;

    assign sb_eff = fb.sign ^ op;
    assign swap   = ({fb.exp, frac_b} > {fa.exp, frac_a});

    assign x_sig    = swap ? sig_b  : sig_a;
    assign y_sig    = swap ? sig_a  : sig_b;
    assign x_exp    = swap ? fb.exp : fa.exp;
    assign y_exp    = swap ? fa.exp : fb.exp;
    assign diff     = x_exp - y_exp;
    assign k        = (diff > 4'd6) ? 3'd6 : diff[2:0];
    assign eff_sub  = fa.sign ^ sb_eff;
    assign res_sign = swap ? sb_eff : fa.sign;

endmodule

// File: rtl/fp9_addsub_seq.sv
// Sequential fp9 add/subtract with bit-serial alignment and normalization.
// Define FP9_ADDSUB_SAT_EN to saturate on exponent overflow instead of wrapping.
module fp9_addsub_seq
    import fp9_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [8:0] i_a,
    input  logic [8:0] i_b,
    input  logic       i_op,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [8:0] o_result,
    output logic       o_ovf
);

    fp9_state_e       state;
    logic [2:0]       cnt;
    logic [SIG_W-1:0] x_sig;
    logic [SIG_W-1:0] y_sig;
    logic [SIG_W:0]   sum;
    logic [EXP_W-1:0] exp_w;
    logic             sign_r;
    logic             eff_sub_r;

    logic [SIG_W-1:0] u_x_sig;
    logic [SIG_W-1:0] u_y_sig;
    logic [EXP_W-1:0] u_x_exp;
    logic [2:0]       u_k;
    logic             u_eff_sub;
    logic             u_sign;

    logic [SIG_W:0]   n_sum;
    logic [EXP_W-1:0] n_exp;
    logic             n_zero;
    logic             n_ovf;
    logic             n_done;
    logic [8:0]       n_result;

    fp9_unpack u_unpack (
        .a        (i_a),
        .b        (i_b),
        .op       (i_op),
        .x_sig    (u_x_sig),
        .y_sig    (u_y_sig),
        .x_exp    (u_x_exp),
        .k        (u_k),
        .eff_sub  (u_eff_sub),
        .res_sign (u_sign)
    );

    assign o_ready = (state == ST_IDLE);

    // One normalization action; the FSM leaves NORM in the same cycle the
    // action yields a normalized (or zero) sum.
    always_comb begin
        n_sum  = sum;
        n_exp  = exp_w;
        n_zero = 1'b0;
        n_ovf  = 1'b0;
        if (sum[SIG_W]) begin
            n_sum = sum >> 1;
            n_exp = exp_w + 4'd1;
            n_ovf = (exp_w == EXP_W'(EXP_MAX));
        end else if (sum == '0) begin
            n_zero = 1'b1;
        end else if (!sum[SIG_W-1]) begin
            if (exp_w == 4'd1) begin
                n_zero = 1'b1;
            end else begin
                n_sum = sum << 1;
                n_exp = exp_w - 4'd1;
            end
        end
        n_done = n_zero | (n_sum[SIG_W-1] & ~n_sum[SIG_W]);

        if (n_zero) begin
            n_result = '0;
`ifdef FP9_ADDSUB_SAT_EN
        end else if (n_ovf) begin
            n_result = {sign_r, 4'hF, 4'hF};
`endif
        end else begin
            n_result = {sign_r, n_exp, n_sum[4:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            x_sig     <= '0;
            y_sig     <= '0;
            sum       <= '0;
            exp_w     <= '0;
            sign_r    <= 1'b0;
            eff_sub_r <= 1'b0;
            o_valid   <= 1'b0;
            o_result  <= '0;
            o_ovf     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        x_sig     <= u_x_sig;
                        y_sig     <= u_y_sig;
                        exp_w     <= u_x_exp;
                        cnt       <= u_k;
                        eff_sub_r <= u_eff_sub;
                        sign_r    <= u_sign;
                        state     <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (cnt != '0) begin
                        y_sig <= y_sig >> 1;
                        cnt   <= cnt - 3'd1;
                    end
                    if (cnt <= 3'd1) state <= ST_ADD;
                end
                ST_ADD: begin
                    sum   <= eff_sub_r ? ({1'b0, x_sig} - {1'b0, y_sig})
                                       : ({1'b0, x_sig} + {1'b0, y_sig});
                    state <= ST_NORM;
                end
                ST_NORM: begin
                    sum   <= n_sum;
                    exp_w <= n_exp;
                    if (n_done) begin
                        o_valid  <= 1'b1;
                        o_result <= n_result;
                        o_ovf    <= n_ovf;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp9_addsub_seq.sv
// Randomized self-checking bench for fp9_addsub_seq against an integer reference model.
module tb_fp9_addsub_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [8:0] i_a;
    logic [8:0] i_b;
    logic       i_op;
    logic       o_valid;
    logic       i_ready;
    logic [8:0] o_result;
    logic       o_ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp9_addsub_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_op     (i_op),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_ovf    (o_ovf)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Value-level model: integer significands, shift by division, loop normalization.
    task automatic ref_model(input logic [8:0] a, input logic [8:0] b, input logic op,
                             output logic [8:0] res, output logic ovf, output int lat);
        int ea, fa, eb, fb, sa, sb;
        int ex, xs, ey, ys, sx, k, s, e, m;
        bit zero;
        ea = int'(a[7:4]); fa = (ea == 0) ? 0 : int'(a[3:0]); sa = int'(a[8]);
        eb = int'(b[7:4]); fb = (eb == 0) ? 0 : int'(b[3:0]); sb = int'(b[8] ^ op);
        if (eb * 16 + fb > ea * 16 + fa) begin
            ex = eb; xs = (eb == 0) ? 0 : 32 + 2 * fb; sx = sb;
            ey = ea; ys = (ea == 0) ? 0 : 32 + 2 * fa;
        end else begin
            ex = ea; xs = (ea == 0) ? 0 : 32 + 2 * fa; sx = sa;
            ey = eb; ys = (eb == 0) ? 0 : 32 + 2 * fb;
        end
        k = ex - ey;
        if (k > 6) k = 6;
        ys = ys / (1 << k);
        s = (sa != sb) ? xs - ys : xs + ys;
        e = ex; m = 0; zero = 0; ovf = 0;
        forever begin
            if (s >= 64) begin
                s = s / 2; e = e + 1; m++;
                if (e > 15) ovf = 1;
                break;
            end else if (s == 0) begin
                zero = 1; m++;
                break;
            end else if (s < 32) begin
                m++;
                if (e - 1 == 0) begin
                    zero = 1;
                    break;
                end
                s = s * 2; e = e - 1;
            end else begin
                break;
            end
        end
        if (zero) res = 9'h000;
`ifdef FP9_ADDSUB_SAT_EN
        else if (ovf) res = {sx[0], 8'hFF};
`endif
        else res = {sx[0], 4'(e % 16), 4'((s / 2) % 16)};
        lat = ((k > 1) ? k : 1) + 1 + ((m > 1) ? m : 1);
    endtask

    task automatic run_op(input logic [8:0] a, input logic [8:0] b, input logic op,
                          input int stall, input bit intrude);
        logic [8:0] er;
        logic       eo;
        int         el;
        int         n;
        ref_model(a, b, op, er, eo, el);
        @(negedge clk);
        n = 0;
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_idle", o_ready, 1);
        i_a = a; i_b = b; i_op = op; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        check("busy_ready", o_ready, 0);
        n = 0;
        while (!o_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, el);
        check("result", o_result, er);
        check("ovf", o_ovf, eo);
        for (int i = 0; i < stall; i++) begin
            if (intrude) begin
                i_valid = 1'b1;
                i_a = 9'($urandom);
                i_b = 9'($urandom);
            end
            @(negedge clk);
            check("hold_valid", o_valid, 1);
            check("hold_result", o_result, er);
            check("hold_ovf", o_ovf, eo);
            check("hold_ready", o_ready, 0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("handoff_valid", o_valid, 0);
        check("handoff_ready", o_ready, 1);
        if (intrude) begin
            repeat (3) begin
                @(negedge clk);
                check("no_second_result", o_valid, 0);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_a = '0; i_b = '0; i_op = 1'b0;
        #12;
        check("rst_valid", o_valid, 0);
        check("rst_result", o_result, 0);
        check("rst_ovf", o_ovf, 0);
        check("rst_ready", o_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(9'h090, 9'h080, 1'b1, 0, 1'b0);
        run_op(9'h088, 9'h088, 1'b0, 0, 1'b0);
        run_op(9'h080, 9'h080, 1'b1, 0, 1'b0);
        run_op(9'h000, 9'h180, 1'b0, 0, 1'b0);
        run_op(9'h000, 9'h000, 1'b1, 0, 1'b0);
        run_op(9'h0FF, 9'h0FF, 1'b0, 0, 1'b0);
        run_op(9'h1FF, 9'h0FF, 1'b1, 0, 1'b0);
        run_op(9'h01F, 9'h010, 1'b1, 0, 1'b0);
        run_op(9'h090, 9'h080, 1'b1, 5, 1'b1);

        // Reset in the third ALIGN cycle of a k=6 request.
        @(negedge clk);
        i_a = 9'h0F0; i_b = 9'h080; i_op = 1'b0; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", o_valid, 0);
        check("midrst_ready", o_ready, 1);
        check("midrst_result", o_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("midrst_no_valid", o_valid, 0);
        end
        run_op(9'h090, 9'h080, 1'b1, 0, 1'b0);

        repeat (300) begin
            logic [8:0] ra;
            logic [8:0] rb;
            ra = 9'($urandom);
            rb = 9'($urandom);
            if ($urandom_range(7) == 0) ra[7:4] = 4'h0;
            if ($urandom_range(7) == 0) rb[7:4] = 4'h0;
            if ($urandom_range(5) == 0) begin
                ra[7:4] = 4'hF;
                rb[7:4] = 4'(13 + $urandom_range(2));
            end
            run_op(ra, rb, 1'($urandom), int'($urandom_range(3)), ($urandom_range(3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
